// File: rtl/spi_word_rx.sv
// SPI receive path: synchronizes sck/ss_n/mosi into clk, assembles WORD_BITS-bit
// words and presents them on a held valid/ack handshake with overrun and frame-error flags.
module spi_word_rx #(
   parameter int WORD_BITS = 16,
   parameter bit SHIFT_MSB = 1'b1
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 sck,
   input  logic                 ss_n,
   input  logic                 mosi,
   input  logic                 rx_ack,
   output logic [WORD_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 overrun,
   output logic                 frame_error,
   output logic                 busy
);

   localparam int CW = $clog2(WORD_BITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(WORD_BITS - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t                state_r;
   logic [CW-1:0]         cnt_r;
   logic [WORD_BITS-1:0]  sr_r;
   logic [WORD_BITS-1:0]  shifted_s;
   logic                  sck_meta_r, sck_sync_r, sck_prev_r;
   logic                  ss_meta_r, ss_sync_r;
   logic                  mosi_meta_r, mosi_sync_r;
   logic                  sck_rise_s;
   logic                  complete_s;

   // Two-flop synchronizers; sck gets a third flop so mosi lines up with the detected edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sck_meta_r  <= 1'b0;
         sck_sync_r  <= 1'b0;
         sck_prev_r  <= 1'b0;
         ss_meta_r   <= 1'b1;
         ss_sync_r   <= 1'b1;
         mosi_meta_r <= 1'b1;
         mosi_sync_r <= 1'b1;
      end else begin
         sck_meta_r  <= sck;
         sck_sync_r  <= sck_meta_r;
         sck_prev_r  <= sck_sync_r;
         ss_meta_r   <= ss_n;
         ss_sync_r   <= ss_meta_r;
         mosi_meta_r <= mosi;
         mosi_sync_r <= mosi_meta_r;
      end
   end

   assign sck_rise_s = sck_sync_r & ~sck_prev_r;
   // ss_n deassertion takes priority over a coincident sck edge.
   assign complete_s = (state_r == RECV) & ~ss_sync_r & sck_rise_s & (cnt_r == CNT_LAST);

   // Next shift-register value with the current synced mosi bit folded in.
   always_comb begin
      shifted_s = '0;
      if (SHIFT_MSB) begin
         shifted_s = {sr_r[WORD_BITS-2:0], mosi_sync_r};
      end else begin
         shifted_s = {mosi_sync_r, sr_r[WORD_BITS-1:1]};
      end
   end

   // Frame sequencing FSM with bit counter, shift register, busy and frame_error.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         sr_r        <= '0;
         busy        <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!ss_sync_r) begin
                  state_r <= RECV;
                  cnt_r   <= '0;
                  sr_r    <= '0;
                  busy    <= 1'b1;
               end else begin
                  busy    <= 1'b0;
               end
            end
            RECV: begin
               if (ss_sync_r) begin
                  state_r     <= IDLE;
                  busy        <= 1'b0;
                  frame_error <= (cnt_r != '0);
               end else if (sck_rise_s) begin
                  sr_r <= shifted_s;
                  if (cnt_r == CNT_LAST) begin
                     cnt_r <= '0;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end else begin
                  busy <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Output word register with valid/ack handshake and sticky overrun.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else if (complete_s) begin
         rx_data  <= shifted_s;
         rx_valid <= 1'b1;
         if (rx_ack) begin
            overrun <= 1'b0;
         end else if (rx_valid) begin
            overrun <= 1'b1;
         end else begin
            overrun <= overrun;
         end
      end else if (rx_ack) begin
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         rx_valid <= rx_valid;
         overrun  <= overrun;
      end
   end

endmodule

// File: tb/tb_spi_word_rx.sv
// Randomized self-checking bench: an MSB-first and an LSB-first receiver share the
// same SPI bus; expected words are computed arithmetically from the transmitted bits.
module tb_spi_word_rx;

   localparam int WB = 8;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic sck = 1'b0;
   logic ss_n = 1'b1;
   logic mosi = 1'b1;
   logic rx_ack = 1'b0;

   logic [WB-1:0] rx_data_m, rx_data_l;
   logic rx_valid_m, rx_valid_l, overrun_m, overrun_l, fe_m, fe_l, busy_m, busy_l;

   int checks = 0;
   int failures = 0;
   int fe_cnt_m = 0;
   int fe_cnt_l = 0;

   // reference model state
   logic [WB-1:0] exp_m, exp_l;
   logic exp_v, exp_o;
   logic frame_bits[$];

   always #5 clk = ~clk;

   spi_word_rx #(.WORD_BITS(WB), .SHIFT_MSB(1'b1)) u_msb (
      .clk(clk), .n_rst(n_rst), .sck(sck), .ss_n(ss_n), .mosi(mosi), .rx_ack(rx_ack),
      .rx_data(rx_data_m), .rx_valid(rx_valid_m), .overrun(overrun_m),
      .frame_error(fe_m), .busy(busy_m));

   spi_word_rx #(.WORD_BITS(WB), .SHIFT_MSB(1'b0)) u_lsb (
      .clk(clk), .n_rst(n_rst), .sck(sck), .ss_n(ss_n), .mosi(mosi), .rx_ack(rx_ack),
      .rx_data(rx_data_l), .rx_valid(rx_valid_l), .overrun(overrun_l),
      .frame_error(fe_l), .busy(busy_l));

   always @(negedge clk) begin
      if (fe_m) fe_cnt_m++;
      if (fe_l) fe_cnt_l++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: a word completes from the last WB bits sent in the frame.
   task automatic model_complete();
      int base;
      base = frame_bits.size() - WB;
      exp_m = '0;
      exp_l = '0;
      for (int i = 0; i < WB; i++) begin
         exp_m = exp_m + (WB'(frame_bits[base+i]) << (WB - 1 - i));
         exp_l = exp_l + (WB'(frame_bits[base+i]) << i);
      end
      if (exp_v) exp_o = 1'b1;
      exp_v = 1'b1;
   endtask

   task automatic send_bit(input logic b);
      mosi = b;
      wait_clk(4);
      sck = 1'b1;
      frame_bits.push_back(b);
      wait_clk(4);
      sck = 1'b0;
   endtask

   task automatic send_word(input logic [WB-1:0] w);
      for (int i = WB - 1; i >= 0; i--) send_bit(w[i]);
      wait_clk(1);
      model_complete();
   endtask

   task automatic start_frame();
      frame_bits.delete();
      ss_n = 1'b0;
      wait_clk(4);
   endtask

   task automatic end_frame();
      wait_clk(4);
      ss_n = 1'b1;
      wait_clk(6);
   endtask

   task automatic ack_pulse();
      rx_ack = 1'b1;
      wait_clk(1);
      rx_ack = 1'b0;
      exp_v = 1'b0;
      exp_o = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      wait_clk(3);
      checks++;
      if ({rx_data_m, rx_valid_m, overrun_m, fe_m, busy_m, rx_data_l, rx_valid_l, overrun_l, fe_l, busy_l} !== '0) begin
         failures++;
         $display("FAIL reset_state got m=%h/%b%b%b%b l=%h/%b%b%b%b exp all 0", rx_data_m, rx_valid_m,
                  overrun_m, fe_m, busy_m, rx_data_l, rx_valid_l, overrun_l, fe_l, busy_l);
      end
      n_rst = 1'b1;
      exp_m = '0; exp_l = '0; exp_v = 1'b0; exp_o = 1'b0;
      wait_clk(3);
   endtask

   task automatic test_basic();
      logic [WB-1:0] w;
      int n, fe0;
      bit stable;
      w = 8'hA5;
      fe0 = fe_cnt_m;
      start_frame();
      for (int i = WB - 1; i >= 1; i--) send_bit(w[i]);
      mosi = w[0];
      wait_clk(4);
      sck = 1'b1;
      frame_bits.push_back(w[0]);
      n = 0;
      while (!rx_valid_m && n < 4) begin
         wait_clk(1);
         n++;
      end
      checks++;
      if (!(rx_valid_m === 1'b1 && rx_data_m === 8'hA5)) begin
         failures++;
         $display("FAIL basic_latency got valid=%b data=%h after %0d clk, exp valid=1 data=a5 within 4", rx_valid_m, rx_data_m, n);
      end
      wait_clk(4 - n);
      sck = 1'b0;
      model_complete();
      end_frame();
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (rx_valid_m !== 1'b1 || rx_data_m !== exp_m || rx_data_l !== exp_l) stable = 1'b0;
         wait_clk(1);
      end
      checks++;
      if (!stable || exp_m !== 8'hA5) begin
         failures++;
         $display("FAIL basic_hold got m=%h l=%h v=%b exp m=a5 l=%h v=1 held", rx_data_m, rx_data_l, rx_valid_m, exp_l);
      end
      ack_pulse();
      checks++;
      if ({rx_valid_m, overrun_m, rx_valid_l, overrun_l} !== 4'b0000 || fe_cnt_m != fe0) begin
         failures++;
         $display("FAIL basic_ack got v=%b o=%b fe_delta=%0d exp v=0 o=0 fe_delta=0", rx_valid_m, overrun_m, fe_cnt_m - fe0);
      end
   endtask

   task automatic test_lsb();
      logic seq[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      start_frame();
      for (int i = 0; i < 8; i++) send_bit(seq[i]);
      wait_clk(1);
      model_complete();
      checks++;
      if (rx_data_l !== 8'hC5 || rx_data_l !== exp_l || rx_data_m !== exp_m || rx_valid_l !== 1'b1) begin
         failures++;
         $display("FAIL lsb_order got l=%h m=%h v=%b exp l=c5 m=%h v=1", rx_data_l, rx_data_m, rx_valid_l, exp_m);
      end
      end_frame();
      ack_pulse();
   endtask

   task automatic test_back_to_back();
      start_frame();
      send_word(8'h3C);
      checks++;
      if (rx_data_m !== exp_m || rx_data_l !== exp_l || rx_valid_m !== 1'b1 || busy_m !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first got m=%h l=%h v=%b busy=%b exp m=%h l=%h v=1 busy=1", rx_data_m, rx_data_l, rx_valid_m, busy_m, exp_m, exp_l);
      end
      ack_pulse();
      checks++;
      if (rx_valid_m !== 1'b0 || busy_m !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ack got v=%b busy=%b exp v=0 busy=1", rx_valid_m, busy_m);
      end
      send_word(8'hC3);
      checks++;
      if (rx_data_m !== 8'hC3 || rx_data_l !== exp_l || rx_valid_m !== 1'b1 || overrun_m !== 1'b0 || busy_m !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second got m=%h l=%h v=%b o=%b busy=%b exp m=c3 l=%h v=1 o=0 busy=1",
                  rx_data_m, rx_data_l, rx_valid_m, overrun_m, busy_m, exp_l);
      end
      end_frame();
      ack_pulse();
   endtask

   task automatic test_overrun();
      start_frame();
      send_word(8'h11);
      send_word(8'h22);
      end_frame();
      checks++;
      if ({rx_data_m, rx_valid_m, overrun_m} !== {8'h22, 1'b1, 1'b1} || {rx_data_l, rx_valid_l, overrun_l} !== {exp_l, exp_v, exp_o}) begin
         failures++;
         $display("FAIL overrun_set got m=%h/%b/%b l=%h/%b/%b exp m=22/1/1 l=%h/%b/%b",
                  rx_data_m, rx_valid_m, overrun_m, rx_data_l, rx_valid_l, overrun_l, exp_l, exp_v, exp_o);
      end
      ack_pulse();
      checks++;
      if ({rx_valid_m, overrun_m, rx_valid_l, overrun_l} !== 4'b0000) begin
         failures++;
         $display("FAIL overrun_clear got v=%b o=%b exp v=0 o=0", rx_valid_m, overrun_m);
      end
   endtask

   task automatic test_frame_error();
      int fe0;
      fe0 = fe_cnt_m;
      start_frame();
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
      end_frame();
      checks++;
      if (fe_cnt_m != fe0 + 1 || fe_cnt_l != fe_cnt_m || rx_valid_m !== 1'b0) begin
         failures++;
         $display("FAIL frame_error_pulse got cycles=%0d/%0d v=%b exp cycles=1/1 v=0", fe_cnt_m - fe0, fe_cnt_l - fe0, rx_valid_m);
      end
      fe0 = fe_cnt_m;
      start_frame();
      send_word(8'h81);
      end_frame();
      checks++;
      if (rx_data_m !== 8'h81 || rx_data_l !== exp_l || rx_valid_m !== 1'b1 || fe_cnt_m != fe0) begin
         failures++;
         $display("FAIL frame_after_error got m=%h l=%h v=%b fe_delta=%0d exp m=81 l=%h v=1 fe_delta=0",
                  rx_data_m, rx_data_l, rx_valid_m, fe_cnt_m - fe0, exp_l);
      end
      ack_pulse();
   endtask

   task automatic test_reset_mid();
      int fe0;
      start_frame();
      send_word(8'h5A);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      #3;
      n_rst = 1'b0;
      #1;
      checks++;
      if ({rx_data_m, rx_valid_m, overrun_m, fe_m, busy_m, rx_data_l, rx_valid_l, busy_l} !== '0) begin
         failures++;
         $display("FAIL reset_mid got m=%h v=%b o=%b fe=%b busy=%b exp all 0", rx_data_m, rx_valid_m, overrun_m, fe_m, busy_m);
      end
      ss_n = 1'b1;
      sck = 1'b0;
      exp_m = '0; exp_l = '0; exp_v = 1'b0; exp_o = 1'b0;
      wait_clk(3);
      n_rst = 1'b1;
      wait_clk(3);
      fe0 = fe_cnt_m;
      start_frame();
      send_word(8'hFF);
      end_frame();
      checks++;
      if (rx_data_m !== 8'hFF || rx_data_l !== 8'hFF || rx_valid_m !== 1'b1 || overrun_m !== 1'b0 || fe_cnt_m != fe0) begin
         failures++;
         $display("FAIL reset_recover got m=%h l=%h v=%b o=%b fe_delta=%0d exp ff/ff/1/0/0",
                  rx_data_m, rx_data_l, rx_valid_m, overrun_m, fe_cnt_m - fe0);
      end
      ack_pulse();
   endtask

   task automatic test_random();
      int nw, tail, fe0;
      for (int f = 0; f < 8; f++) begin
         fe0 = fe_cnt_m;
         start_frame();
         nw = $urandom_range(1, 3);
         for (int k = 0; k < nw; k++) begin
            send_word(WB'($urandom));
            checks++;
            if ({rx_data_m, rx_valid_m, overrun_m, rx_data_l, rx_valid_l, overrun_l} !== {exp_m, exp_v, exp_o, exp_l, exp_v, exp_o}) begin
               failures++;
               $display("FAIL random_word f%0d w%0d got m=%h/%b/%b l=%h/%b/%b exp m=%h l=%h v=%b o=%b", f, k,
                        rx_data_m, rx_valid_m, overrun_m, rx_data_l, rx_valid_l, overrun_l, exp_m, exp_l, exp_v, exp_o);
            end
            if ($urandom_range(0, 1) == 1) ack_pulse();
         end
         tail = ($urandom_range(0, 1) == 1) ? $urandom_range(1, WB - 1) : 0;
         for (int i = 0; i < tail; i++) send_bit(1'($urandom_range(0, 1)));
         end_frame();
         checks++;
         if (fe_cnt_m - fe0 != ((tail != 0) ? 1 : 0) || fe_cnt_l != fe_cnt_m || rx_valid_m !== exp_v || overrun_m !== exp_o) begin
            failures++;
            $display("FAIL random_frame_end f%0d got fe_delta=%0d v=%b o=%b exp fe_delta=%0d v=%b o=%b", f,
                     fe_cnt_m - fe0, rx_valid_m, overrun_m, (tail != 0) ? 1 : 0, exp_v, exp_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lsb();
      test_back_to_back();
      test_overrun();
      test_frame_error();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
